// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and encoded-word handshake bundle for instr_encoder
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_shamt;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;

    modport master (
        output in_valid, in_kind, in_rd, in_rs, in_rt, in_shamt, in_imm, out_ready,
        input  in_ready, out_valid, out_instr
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_rs, in_rt, in_shamt, in_imm, out_ready,
        output in_ready, out_valid, out_instr
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: encodes R/I-type requests into 32-bit words queued in a small FIFO
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    instr_encoder_if.slave         bus,
    input  logic                   clr_err,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] full = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          is_r, is_i, legal, push, pop, bad;
    logic [4:0]    opcode;
    logic [31:0]   word;

    always_comb begin
        is_r = bus.in_kind <= 4'd5;
        is_i = bus.in_kind inside {4'd8, 4'd9, 4'd10};
        // immediate must be representable as a 17-bit signed field
        legal = is_r || (is_i && (&bus.in_imm[31:16] || ~|bus.in_imm[31:16]));
        opcode = bus.in_kind == 4'd8 ? 5'b00101 : bus.in_kind == 4'd9 ? 5'b00111 : 5'b01000;
        word = is_r ? {5'b0, bus.in_rd, bus.in_rs, bus.in_rt, bus.in_shamt, 1'b0, bus.in_kind, 2'b00}
                    : {opcode, bus.in_rd, bus.in_rs, bus.in_imm[16:0]};
        push = bus.in_valid && bus.in_ready && legal;
        bad = bus.in_valid && bus.in_ready && !legal;
        pop = bus.out_valid && bus.out_ready;
    end

    assign bus.in_ready  = count < full;
    assign bus.out_valid = count != '0;
    assign bus.out_instr = bus.out_valid ? mem[rd_ptr] : 32'd0;

    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= word;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW)'(1);
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            err   <= bad || (err && !clr_err);
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors for instr_encoder with hand-computed words
module tb_instr_encoder;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr_err = 1'b0;
    logic [2:0] count;
    logic       err;
    int         n_cmp = 0;
    int         n_bad = 0;

    instr_encoder_if bus ();

    instr_encoder #(.DEPTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .clr_err (clr_err),
        .count   (count),
        .err     (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic [3:0] kind, input logic [4:0] rd, rs, rt, shamt, input logic [31:0] imm);
        bus.in_valid = 1'b1;
        bus.in_kind  = kind;
        bus.in_rd    = rd;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_shamt = shamt;
        bus.in_imm   = imm;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        req(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        bus.in_valid = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step();
        step();
        #2 reset_n = 1'b1;

        // add rd=3 rs=1 rt=2, one-cycle latency
        req(4'd0, 5'd3, 5'd1, 5'd2, 5'd0, 32'd0);
        check("add_ready", 32'(bus.in_ready), 32'd1);
        #1 check("add_no_comb", 32'(bus.out_valid), 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("add_count", 32'(count), 32'd1);
        check("add_word", bus.out_instr, 32'h00C22000);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("add_drained", 32'(count), 32'd0);
        check("empty_word", bus.out_instr, 32'd0);

        // addi then lw, in order
        req(4'd8, 5'd1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
        step();
        req(4'd10, 5'd2, 5'd1, 5'd0, 5'd0, 32'd4);
        step();
        bus.in_valid = 1'b0;
        check("i_count", 32'(count), 32'd2);
        check("addi_word", bus.out_instr, 32'h2841FFFF);
        bus.out_ready = 1'b1;
        step();
        check("lw_word", bus.out_instr, 32'h40820004);
        step();
        bus.out_ready = 1'b0;
        check("i_drained", 32'(count), 32'd0);

        // illegal requests push nothing and set err
        req(4'd8, 5'd1, 5'd0, 5'd0, 5'd0, 32'd65536);
        step();
        check("imm_hi_err", 32'(err), 32'd1);
        check("imm_hi_count", 32'(count), 32'd0);
        req(4'd7, 5'd1, 5'd1, 5'd1, 5'd0, 32'd0);
        step();
        check("kind7_count", 32'(count), 32'd0);
        req(4'd15, 5'd1, 5'd1, 5'd1, 5'd0, 32'd0);
        clr_err = 1'b1;
        step();
        check("set_wins", 32'(err), 32'd1);
        check("kind15_count", 32'(count), 32'd0);
        bus.in_valid = 1'b0;
        step();
        clr_err = 1'b0;
        check("clr_err", 32'(err), 32'd0);

        // immediate range edges are legal
        req(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 32'd65535);
        step();
        req(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, -32'sd65536);
        step();
        bus.in_valid = 1'b0;
        check("edge_err", 32'(err), 32'd0);
        check("edge_count", 32'(count), 32'd2);
        check("imm_max", bus.out_instr, 32'h2800FFFF);
        bus.out_ready = 1'b1;
        step();
        check("imm_min", bus.out_instr, 32'h28010000);
        step();
        bus.out_ready = 1'b0;

        // fill to DEPTH across pointer wrap; sw ignores rt/shamt, sra ignores imm
        req(4'd5, 5'd1, 5'd2, 5'd3, 5'd4, 32'h12345678);
        step();
        req(4'd9, 5'd4, 5'd2, 5'd31, 5'd31, 32'd8);
        step();
        req(4'd0, 5'd3, 5'd1, 5'd2, 5'd0, 32'd0);
        step();
        req(4'd1, 5'd5, 5'd6, 5'd7, 5'd0, 32'd0);
        step();
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(bus.in_ready), 32'd0);
        check("sra_word", bus.out_instr, 32'h00443214);
        req(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("fifth_count", 32'(count), 32'd4);
        check("fifth_no_err", 32'(err), 32'd0);
        check("hold_word", bus.out_instr, 32'h00443214);
        bus.out_ready = 1'b1;
        step();
        check("pop_count", 32'(count), 32'd3);
        check("sw_word", bus.out_instr, 32'h39040008);
        req(4'd10, 5'd2, 5'd1, 5'd0, 5'd0, 32'd4);
        step();
        bus.in_valid = 1'b0;
        check("pushpop_count", 32'(count), 32'd3);
        check("pushpop_word", bus.out_instr, 32'h00C22000);
        step();
        check("order_sub", bus.out_instr, 32'h014C7004);
        step();
        check("order_lw", bus.out_instr, 32'h40820004);
        step();
        bus.out_ready = 1'b0;
        check("wrap_drained", 32'(count), 32'd0);

        // async reset mid-cycle with count=3 and err set
        req(4'd0, 5'd1, 5'd1, 5'd1, 5'd0, 32'd0);
        step();
        step();
        step();
        req(4'd6, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_err", 32'(err), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_word", bus.out_instr, 32'd0);
        check("arst_ready", 32'(bus.in_ready), 32'd1);
        check("arst_err", 32'(err), 32'd0);
        #1 reset_n = 1'b1;
        req(4'd1, 5'd5, 5'd6, 5'd7, 5'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_word", bus.out_instr, 32'h014C7004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
